// File: rtl/uart_rx_line_buffer.sv
// uart_rx_line_buffer
// 8N1 UART receiver that feeds a 16-character text line for an LCD.
// Printable bytes are appended left to right, and the line scrolls left once
// all 16 columns are used. CR clears the line and BS erases the character
// to the left of the cursor. Framing errors are reported and then discarded.

module uart_rx_line_buffer #(
    parameter int CLKS_PER_BIT = 5625
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [4:0] cursor,
    output logic [7:0] L0,
    output logic [7:0] L1,
    output logic [7:0] L2,
    output logic [7:0] L3,
    output logic [7:0] L4,
    output logic [7:0] L5,
    output logic [7:0] L6,
    output logic [7:0] L7,
    output logic [7:0] L8,
    output logic [7:0] L9,
    output logic [7:0] L_A,
    output logic [7:0] L_B,
    output logic [7:0] L_C,
    output logic [7:0] L_D,
    output logic [7:0] L_E,
    output logic [7:0] L_F
);

    // The counter must reach CLKS_PER_BIT-1. This gives 13 bits at 5625.
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Returns true for the printable ASCII range that is written into the line.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             rxd_meta_r;
    logic             rxd_sync_r;
    logic             rxd_prev_r;
    logic             fall_s;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_last_s;
    logic             cnt_half_s;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             data_sample_s;
    logic             stop_sample_s;
    logic             start_ok_s;
    logic [7:0]       line_r [16];

    // Two-flop synchroniser and previous-sample register. They reset high (idle line).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic. Only a fresh 1->0 edge leaves IDLE, so a held-low break never retriggers.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_half_s) begin
                    if (start_ok_s) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (data_sample_s && (bit_idx_r == 3'd7)) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (stop_sample_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: edge detect, counter terminal values and per-state sample strobes.
    always_comb begin
        fall_s        = rxd_prev_r & ~rxd_sync_r;
        cnt_last_s    = (cnt_r == CNT_LAST);
        cnt_half_s    = (cnt_r == CNT_HALF);
        start_ok_s    = ~rxd_sync_r;
        data_sample_s = 1'b0;
        stop_sample_s = 1'b0;
        case (state_r)
            ST_DATA: begin
                data_sample_s = cnt_last_s;
            end
            ST_STOP: begin
                stop_sample_s = cnt_last_s;
            end
            default: begin
                data_sample_s = 1'b0;
                stop_sample_s = 1'b0;
            end
        endcase
    end

    // Bit-period counter. It restarts on every state entry and wraps at the end of each data bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if ((state_nxt_s != state_r) || (state_r == ST_IDLE) || cnt_last_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Data shift register, LSB first. The bit index is held at zero outside DATA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
        end else if (state_r != ST_DATA) begin
            shift_r   <= shift_r;
            bit_idx_r <= 3'd0;
        end else if (data_sample_s) begin
            shift_r   <= {rxd_sync_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
        end else begin
            shift_r   <= shift_r;
            bit_idx_r <= bit_idx_r;
        end
    end

    // Stop-bit check. It produces the one-cycle rx_valid or frame_err pulse and latches good bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else if (stop_sample_s) begin
            if (rxd_sync_r) begin
                rx_data   <= shift_r;
                rx_valid  <= 1'b1;
                frame_err <= 1'b0;
            end else begin
                rx_data   <= rx_data;
                rx_valid  <= 1'b0;
                frame_err <= 1'b1;
            end
        end else begin
            rx_data   <= rx_data;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end
    end

    // Line editor. It acts one cycle after rx_valid and decodes the byte already held in rx_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cursor <= 5'd0;
            for (int i = 0; i < 16; i++) begin
                line_r[i] <= CH_SPACE;
            end
        end else if (rx_valid) begin
            if (is_printable(rx_data)) begin
                if (cursor == 5'd16) begin
                    // Full line: scroll left and put the new character in the last column.
                    for (int i = 0; i < 15; i++) begin
                        line_r[i] <= line_r[i+1];
                    end
                    line_r[15] <= rx_data;
                    cursor     <= cursor;
                end else begin
                    line_r[cursor[3:0]] <= rx_data;
                    cursor              <= cursor + 5'd1;
                end
            end else if (rx_data == CH_CR) begin
                cursor <= 5'd0;
                for (int i = 0; i < 16; i++) begin
                    line_r[i] <= CH_SPACE;
                end
            end else if ((rx_data == CH_BS) && (cursor != 5'd0)) begin
                // When cursor is 16, cursor[3:0]-1 wraps to column 15, which is the column to erase.
                line_r[cursor[3:0] - 4'd1] <= CH_SPACE;
                cursor                     <= cursor - 5'd1;
            end else begin
                cursor <= cursor;
            end
        end else begin
            cursor <= cursor;
        end
    end

    assign L0  = line_r[0];
    assign L1  = line_r[1];
    assign L2  = line_r[2];
    assign L3  = line_r[3];
    assign L4  = line_r[4];
    assign L5  = line_r[5];
    assign L6  = line_r[6];
    assign L7  = line_r[7];
    assign L8  = line_r[8];
    assign L9  = line_r[9];
    assign L_A = line_r[10];
    assign L_B = line_r[11];
    assign L_C = line_r[12];
    assign L_D = line_r[13];
    assign L_E = line_r[14];
    assign L_F = line_r[15];

endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// tb_uart_rx_line_buffer
// Table-driven bench with a scoreboard. Each frame sent pushes its expected pulse kind,
// rx_data, cursor and line image. A monitor pops and compares the entry when the DUT pulses.

module tb_uart_rx_line_buffer;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic [4:0] cursor;
    logic [7:0] L0, L1, L2, L3, L4, L5, L6, L7, L8, L9;
    logic [7:0] L_A, L_B, L_C, L_D, L_E, L_F;
    logic [127:0] dut_line;

    assign dut_line = {L_F, L_E, L_D, L_C, L_B, L_A, L9, L8, L7, L6, L5, L4, L3, L2, L1, L0};

    uart_rx_line_buffer #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .cursor(cursor),
        .L0(L0), .L1(L1), .L2(L2), .L3(L3), .L4(L4), .L5(L5), .L6(L6), .L7(L7),
        .L8(L8), .L9(L9), .L_A(L_A), .L_B(L_B), .L_C(L_C), .L_D(L_D), .L_E(L_E), .L_F(L_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic [4:0] exp_cursor;
    } vec_t;

    typedef struct {
        logic         is_err;
        logic [7:0]   data;
        logic [4:0]   cursor;
        logic [127:0] line;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;
    int valid_seen = 0;
    int err_seen = 0;
    int exp_valid = 0;
    int exp_err = 0;

    logic [7:0] m_line [16];
    int         m_cursor;
    logic [7:0] m_last;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_line[i] = 8'h20;
        m_cursor = 0;
        m_last   = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] d);
        if (d >= 8'h20 && d <= 8'h7E) begin
            if (m_cursor < 16) begin
                m_line[m_cursor] = d;
                m_cursor++;
            end else begin
                for (int i = 0; i < 15; i++) m_line[i] = m_line[i+1];
                m_line[15] = d;
            end
        end else if (d == 8'h0D) begin
            for (int i = 0; i < 16; i++) m_line[i] = 8'h20;
            m_cursor = 0;
        end else if (d == 8'h08 && m_cursor > 0) begin
            m_cursor--;
            m_line[m_cursor] = 8'h20;
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = m_line[i];
        return f;
    endfunction

    // Updates the model for one frame and queues what the DUT must show for it.
    task automatic push_frame(input logic [7:0] d, input logic stop_ok,
                              input logic use_cur, input logic [4:0] cur);
        exp_t e;
        if (stop_ok) begin
            m_last = d;
            model_byte(d);
            exp_valid++;
        end else begin
            exp_err++;
        end
        e.is_err = !stop_ok;
        e.data   = m_last;
        e.cursor = use_cur ? cur : 5'(m_cursor);
        e.line   = model_flat();
        sb_q.push_back(e);
    endtask

    // Drives start, 8 data bits and the stop bit, then leaves rxd at the stop level.
    task automatic send_bits(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d, stop);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic add_vec(input logic [7:0] d, input logic s, input logic [4:0] c);
        vec_t v;
        v.data = d; v.stop_ok = s; v.exp_cursor = c;
        vecs.push_back(v);
    endtask

    // Scoreboard monitor. It compares each pulse and, one cycle later, the edited line.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && (rx_valid === 1'b1 || frame_err === 1'b1)) begin
                check("pulse_exclusive", {126'd0, rx_valid, frame_err} == 128'd3 ? 128'd1 : 128'd0, 128'd0);
                if (rx_valid) valid_seen++; else err_seen++;
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {126'd0, rx_valid, frame_err}, 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_kind", {127'd0, frame_err}, {127'd0, e.is_err});
                    check("rx_data", {120'd0, rx_data}, {120'd0, e.data});
                    @(negedge clk);
                    check("pulse_width", {126'd0, rx_valid, frame_err}, 128'd0);
                    check("cursor", {123'd0, cursor}, {123'd0, e.cursor});
                    check("line", dut_line, e.line);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses_before;

        // Stimulus table: byte, stop bit good, expected cursor after the line edit.
        add_vec(8'h41, 1'b1, 5'd1);
        add_vec(8'h0D, 1'b1, 5'd0);
        for (int i = 0; i < 10; i++) add_vec(8'(8'h30 + i), 1'b1, 5'(i + 1));
        for (int i = 0; i < 6; i++)  add_vec(8'(8'h41 + i), 1'b1, 5'(i + 11));
        add_vec(8'h47, 1'b1, 5'd16);
        add_vec(8'h0D, 1'b1, 5'd0);
        add_vec(8'h41, 1'b1, 5'd1);
        add_vec(8'h42, 1'b1, 5'd2);
        add_vec(8'h08, 1'b1, 5'd1);
        add_vec(8'h08, 1'b1, 5'd0);
        add_vec(8'h08, 1'b1, 5'd0);
        add_vec(8'h55, 1'b0, 5'd0);
        add_vec(8'h0A, 1'b1, 5'd0);
        add_vec(8'h7F, 1'b1, 5'd0);
        add_vec(8'h7E, 1'b1, 5'd1);

        model_reset();
        rxd   = 1'b1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_rx_data", {120'd0, rx_data}, 128'd0);
        check("reset_pulses", {126'd0, rx_valid, frame_err}, 128'd0);
        check("reset_cursor", {123'd0, cursor}, 128'd0);
        check("reset_line", dut_line, model_flat());
        reset = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        foreach (vecs[k]) begin
            push_frame(vecs[k].data, vecs[k].stop_ok, 1'b1, vecs[k].exp_cursor);
            send_frame(vecs[k].data, vecs[k].stop_ok);
        end

        // Framing error followed by a 40-bit break, then a good byte.
        push_frame(8'h55, 1'b0, 1'b0, 5'd0);
        send_bits(8'h55, 1'b0);
        rxd = 1'b0;
        pulses_before = valid_seen + err_seen;
        repeat (40 * CPB) @(negedge clk);
        check("break_no_pulse", 128'(valid_seen + err_seen), 128'(pulses_before));
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        push_frame(8'h42, 1'b1, 1'b0, 5'd0);
        send_frame(8'h42, 1'b1);

        // Short low glitch on the idle line must be rejected.
        pulses_before = valid_seen + err_seen;
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("glitch_no_pulse", 128'(valid_seen + err_seen), 128'(pulses_before));
        push_frame(8'h48, 1'b1, 1'b0, 5'd0);
        send_frame(8'h48, 1'b1);
        push_frame(8'h49, 1'b1, 1'b0, 5'd0);
        send_frame(8'h49, 1'b1);
        push_frame(8'h0D, 1'b1, 1'b1, 5'd0);
        send_frame(8'h0D, 1'b1);

        // Reset in the middle of bit 4 of a 0x77 frame.
        push_frame(8'h5A, 1'b1, 1'b0, 5'd0);
        send_frame(8'h5A, 1'b1);
        pulses_before = valid_seen + err_seen;
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = (8'h77 >> i) & 8'h01;
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("midreset_rx_data", {120'd0, rx_data}, 128'd0);
        check("midreset_pulses", {126'd0, rx_valid, frame_err}, 128'd0);
        check("midreset_cursor", {123'd0, cursor}, 128'd0);
        check("midreset_line", dut_line, model_flat());
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("midreset_no_pulse", 128'(valid_seen + err_seen), 128'(pulses_before));
        push_frame(8'h5A, 1'b1, 1'b1, 5'd1);
        send_frame(8'h5A, 1'b1);

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 2000 && sb_q.size() != 0; t++) @(negedge clk);
        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        check("valid_count", 128'(valid_seen), 128'(exp_valid));
        check("frame_err_count", 128'(err_seen), 128'(exp_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
